// File: rtl/hall_emulator_if.sv
// Bundles the run controls and the emulated Hall outputs of hall_emulator.
// The master side drives the controls and observes the Hall lines. The slave side is the emulator.
interface hall_emulator_if #(
    parameter int PERIOD_BITS = 24,
    parameter int REV_BITS    = 16
);
    logic                   en;
    logic                   dir;
    logic [PERIOD_BITS-1:0] sector_period;
    logic [1:0]             fault_mode;
    logic                   hall_1;
    logic                   hall_2;
    logic                   hall_3;
    logic [2:0]             sector;
    logic                   step_pulse;
    logic [REV_BITS-1:0]    rev_count;

    modport master (
        output en, dir, sector_period, fault_mode,
        input  hall_1, hall_2, hall_3, sector, step_pulse, rev_count
    );

    modport slave (
        input  en, dir, sector_period, fault_mode,
        output hall_1, hall_2, hall_3, sector, step_pulse, rev_count
    );
endinterface

// File: rtl/hall_emulator.sv
// Hall-sensor emulator. It steps through the six valid Hall codes at a programmable
// dwell time in either direction, and counts electrical revolutions.
// It can force the invalid codes 000 and 111 so that downstream fault handling can be exercised.
module hall_emulator #(
    parameter int PERIOD_BITS = 24,
    parameter int REV_BITS    = 16
) (
    input  logic            clk_ctrl,
    input  logic            rst_ctrl,
    hall_emulator_if.slave  bus
);
    localparam logic [1:0] FM_NORMAL = 2'b00;
    localparam logic [1:0] FM_ZERO   = 2'b01;
    localparam logic [1:0] FM_ONE    = 2'b10;
    localparam logic [1:0] FM_FREEZE = 2'b11;

    // Sector index to {hall_3, hall_2, hall_1}. Neighbouring sectors differ in one bit.
    function automatic logic [2:0] hall_code(input logic [2:0] s);
        case (s)
            3'd0:    hall_code = 3'b001;
            3'd1:    hall_code = 3'b101;
            3'd2:    hall_code = 3'b100;
            3'd3:    hall_code = 3'b110;
            3'd4:    hall_code = 3'b010;
            default: hall_code = 3'b011;
        endcase
    endfunction

    logic [PERIOD_BITS-1:0] cnt_q, cnt_d;
    logic [PERIOD_BITS-1:0] period_q, period_d;
    logic [2:0]             sector_q, sector_d;
    logic [REV_BITS-1:0]    rev_q, rev_d;
    logic [2:0]             hall_q, hall_d;
    logic                   step_pulse_q, step_pulse_d;
    logic                   run;
    logic                   step;

    // Next-state logic: dwell counting, period latch, sector stepping, revolution count, Hall output selection.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
        cnt_d        = cnt_q;
        period_d     = period_q;
        sector_d     = sector_q;
        rev_d        = rev_q;
        hall_d       = hall_q;
        step_pulse_d = 1'b0;

        run  = bus.en && (period_q != '0) && (bus.fault_mode != FM_FREEZE);
        step = run && (cnt_q == period_q - PERIOD_BITS'(1));

        if (!bus.en || period_q == '0) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = step ? '0 : cnt_q + PERIOD_BITS'(1);
        end

        // A new period takes effect only at a sector boundary, or while idle or stalled.
        if (!bus.en || period_q == '0 || step) begin
            period_d = bus.sector_period;
        end

        if (step) begin
            if (!bus.dir) begin
                sector_d = (sector_q == 3'd5) ? 3'd0 : sector_q + 3'd1;
                if (sector_q == 3'd5) rev_d = rev_q + REV_BITS'(1);
            end else begin
                sector_d = (sector_q == 3'd0) ? 3'd5 : sector_q - 3'd1;
                if (sector_q == 3'd0) rev_d = rev_q - REV_BITS'(1);
            end
        end

        // Forced codes mask the output only. Internal stepping continues underneath.
        case (bus.fault_mode)
            FM_ZERO: hall_d = 3'b000;
            FM_ONE:  hall_d = 3'b111;
            default: hall_d = hall_code(sector_d);
        endcase

        // A step can only occur when fault_mode is not FREEZE. The pulse is also suppressed while a code is forced.
        step_pulse_d = step && (bus.fault_mode == FM_NORMAL);
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk_ctrl) begin
        // NOTE: sequential state uses non-blocking assignments, so all flops update together at the edge.
        if (rst_ctrl) begin
            cnt_q        <= '0;
            period_q     <= '0;
            sector_q     <= 3'd0;
            rev_q        <= '0;
            hall_q       <= 3'b001;
            step_pulse_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            period_q     <= period_d;
            sector_q     <= sector_d;
            rev_q        <= rev_d;
            hall_q       <= hall_d;
            step_pulse_q <= step_pulse_d;
        end
    end

    assign bus.hall_1     = hall_q[0];
    assign bus.hall_2     = hall_q[1];
    assign bus.hall_3     = hall_q[2];
    assign bus.sector     = sector_q;
    assign bus.step_pulse = step_pulse_q;
    assign bus.rev_count  = rev_q;
endmodule

// File: tb/tb_hall_emulator.sv
// Self-checking bench for hall_emulator. Directed scenarios are followed by a randomized run.
// Every edge is compared against a behavioural model that counts elapsed dwell cycles
// and uses modulo-6 sector arithmetic.
module tb_hall_emulator;
    localparam int PB = 24;
    localparam int RB = 16;

    logic clk_ctrl = 1'b0;
    logic rst_ctrl;

    hall_emulator_if #(.PERIOD_BITS(PB), .REV_BITS(RB)) bus ();

    hall_emulator #(.PERIOD_BITS(PB), .REV_BITS(RB)) dut (
        .clk_ctrl (clk_ctrl),
        .rst_ctrl (rst_ctrl),
        .bus      (bus)
    );

    always #5 clk_ctrl = ~clk_ctrl;

    // Hall code for each sector, as {hall_3, hall_2, hall_1}.
    int code_tbl [6] = '{1, 5, 4, 6, 2, 3};

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state.
    int m_sector, m_elapsed, m_period, m_rev, m_hall, m_pulse;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        else n_pass++;
    endtask

    // Applies one clock edge to the model, using the inputs that were present at that edge.
    task automatic model_edge(input bit rst, input bit en, input bit dir, input int p, input int fm);
        bit running, stepped;
        if (rst) begin
            m_sector = 0; m_elapsed = 0; m_period = 0; m_rev = 0; m_hall = 1; m_pulse = 0;
        end else begin
            stepped = 1'b0;
            running = en && (m_period != 0) && (fm != 3);
            if (running) begin
                m_elapsed = m_elapsed + 1;
                if (m_elapsed == m_period) begin
                    m_elapsed = 0;
                    stepped = 1'b1;
                end
            end
            if (!en) m_elapsed = 0;
            if (!en || m_period == 0 || stepped) m_period = p;
            if (stepped) begin
                if (!dir) begin
                    if (m_sector == 5) m_rev = (m_rev + 1) % 65536;
                    m_sector = (m_sector + 1) % 6;
                end else begin
                    if (m_sector == 0) m_rev = (m_rev + 65535) % 65536;
                    m_sector = (m_sector + 5) % 6;
                end
            end
            m_hall  = (fm == 1) ? 0 : (fm == 2) ? 7 : code_tbl[m_sector];
            m_pulse = (stepped && fm == 0) ? 1 : 0;
        end
    endtask

    function automatic logic [31:0] hall_obs();
        return {29'd0, bus.hall_3, bus.hall_2, bus.hall_1};
    endfunction

    // One clock edge: advance the model, then sample the DUT 1 time unit after the edge and compare.
    task automatic tick();
        @(posedge clk_ctrl);
        model_edge(rst_ctrl, bus.en, bus.dir, int'(bus.sector_period), int'(bus.fault_mode));
        #1;
        check("hall",       hall_obs(),                  m_hall);
        check("sector",     {29'd0, bus.sector},         m_sector);
        check("step_pulse", {31'd0, bus.step_pulse},     m_pulse);
        check("rev_count",  {16'd0, bus.rev_count},      m_rev);
    endtask

    task automatic run_ticks(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (bus.step_pulse) pulses++;
        end
    endtask

    // Returns the number of edges until step_pulse is seen, or -1 if the bound of 40 edges expires.
    task automatic edges_to_pulse(output int n);
        bit found = 1'b0;
        int i = 0;
        n = -1;
        while (!found && i < 40) begin
            tick();
            i++;
            if (bus.step_pulse) begin
                found = 1'b1;
                n = i;
            end
        end
    endtask

    int pulses, n, k;
    int fwd_exp [6] = '{5, 4, 6, 2, 3, 1};
    int rev_exp [6] = '{3, 2, 6, 4, 5, 1};

    initial begin
        rst_ctrl = 1'b1; bus.en = 1'b0; bus.dir = 1'b0; bus.sector_period = 24'd4; bus.fault_mode = 2'b00;
        model_edge(1'b1, 1'b0, 1'b0, 0, 0);

        // Reset, then hold en=0 for 10 cycles.
        tick(); tick();
        rst_ctrl = 1'b0;
        run_ticks(10, pulses);
        check("idle_hall",   hall_obs(), 32'h1);
        check("idle_sector", {29'd0, bus.sector}, 32'd0);
        check("idle_pulses", pulses, 0);

        // Forward rotation at P=4, with the period already latched.
        bus.en = 1'b1;
        pulses = 0;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (bus.step_pulse) begin
                if (pulses < 6) check("fwd_seq", hall_obs(), fwd_exp[pulses]);
                pulses++;
                check("fwd_pulse_phase", (i + 1) % 4, 0);
            end
        end
        check("fwd_pulses", pulses, 6);
        check("fwd_rev",    {16'd0, bus.rev_count}, 32'd1);

        // Reverse rotation at P=3, starting from the reset state.
        rst_ctrl = 1'b1; bus.en = 1'b0; bus.sector_period = 24'd3;
        tick();
        rst_ctrl = 1'b0;
        tick();
        bus.dir = 1'b1; bus.en = 1'b1;
        pulses = 0;
        for (int i = 0; i < 18; i++) begin
            tick();
            if (bus.step_pulse) begin
                if (pulses < 6) check("rev_seq", hall_obs(), rev_exp[pulses]);
                pulses++;
            end
        end
        check("rev_rev", {16'd0, bus.rev_count}, 32'h0000FFFF);
        // Flip dir mid-sector. The next step must move forward from sector 0 to sector 1.
        tick();
        bus.dir = 1'b0;
        tick(); tick();
        check("flip_sector", {29'd0, bus.sector}, 32'd1);
        check("flip_hall",   hall_obs(), 32'h5);

        // Period change to 8 at cycle 2 of a P=4 sector.
        bus.en = 1'b0; bus.sector_period = 24'd4;
        tick();
        bus.en = 1'b1;
        tick(); tick();
        bus.sector_period = 24'd8;
        edges_to_pulse(n);
        check("dwell_before_change", n, 2);
        edges_to_pulse(n);
        check("dwell_after_change", n, 8);

        // Forced code 000 for 6 cycles at P=4.
        bus.en = 1'b0; bus.sector_period = 24'd4;
        tick();
        bus.en = 1'b1; bus.fault_mode = 2'b01;
        tick();
        check("fault_zero_hall", hall_obs(), 32'h0);
        run_ticks(5, pulses);
        check("fault_pulses", pulses, 0);
        check("fault_sector", {29'd0, bus.sector}, 32'd4);
        bus.fault_mode = 2'b00;
        tick();
        check("fault_release_hall", hall_obs(), 32'h2);
        bus.fault_mode = 2'b11;
        run_ticks(6, pulses);
        check("freeze_sector", {29'd0, bus.sector}, 32'd4);
        check("freeze_hall",   hall_obs(), 32'h2);
        bus.fault_mode = 2'b00;
        tick();

        // A stalled period (P=0) must produce no steps.
        bus.en = 1'b0; bus.sector_period = 24'd0;
        tick();
        bus.en = 1'b1;
        run_ticks(10, pulses);
        check("stall_pulses", pulses, 0);
        check("stall_sector", {29'd0, bus.sector}, 32'd5);

        // Drop en mid-sector, then re-enable. The dwell must restart and run a full P cycles.
        bus.en = 1'b0; bus.sector_period = 24'd5;
        tick();
        bus.en = 1'b1;
        tick(); tick();
        bus.en = 1'b0;
        run_ticks(3, pulses);
        check("hold_hall", hall_obs(), 32'h3);
        bus.en = 1'b1;
        edges_to_pulse(n);
        check("reenable_dwell", n, 5);

        // Randomized run, checked against the model on every edge.
        for (int i = 0; i < 600; i++) begin
            rst_ctrl = ($urandom_range(0, 149) == 0);
            bus.en   = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 7) == 0) bus.sector_period = 24'($urandom_range(0, 5));
            if ($urandom_range(0, 11) == 0) bus.dir = 1'($urandom_range(0, 1));
            k = $urandom_range(0, 19);
            if (k < 2)       bus.fault_mode = 2'($urandom_range(1, 3));
            else if (k < 6)  bus.fault_mode = 2'b00;
            tick();
        end
        rst_ctrl = 1'b0;

        // Reset asserted mid-run with en=1 and a forced code must still return the reset values.
        bus.en = 1'b1; bus.sector_period = 24'd2; bus.fault_mode = 2'b01; bus.dir = 1'b0;
        repeat (5) tick();
        rst_ctrl = 1'b1;
        tick();
        check("rst_hall",   hall_obs(), 32'h1);
        check("rst_sector", {29'd0, bus.sector}, 32'd0);
        check("rst_rev",    {16'd0, bus.rev_count}, 32'd0);
        check("rst_pulse",  {31'd0, bus.step_pulse}, 32'd0);
        rst_ctrl = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/hall_emulator.md
# hall_emulator

Synthesisable Hall-sensor signal generator for the ESC control domain. It drives the three Hall lines that the six-step commutation logic consumes, so drive and gate logic can be exercised on hardware or in simulation without a motor. It steps through the six valid Hall codes at a programmable dwell time, in either direction, and counts electrical revolutions. It can also inject invalid Hall codes to test fault handling downstream.

## Interface
Parameters:
- PERIOD_BITS, 24, width of the sector dwell counter and period input.
- REV_BITS, 16, width of the signed revolution counter.

Ports:
- clk_ctrl  input  1  control-domain clock; the only clock.
- rst_ctrl  input  1  synchronous, active-high reset.
- en  input  1  run enable; 0 freezes stepping.
- dir  input  1  0 = forward (sector increments), 1 = reverse (sector decrements).
- sector_period  input  PERIOD_BITS  clk_ctrl cycles per sector; 0 = stall.
- fault_mode  input  2  00 normal, 01 force Hall code 000, 10 force 111, 11 freeze stepping.
- hall_1, hall_2, hall_3  output  1 each  registered Hall lines.
- sector  output  3  internal sector index, 0..5.
- step_pulse  output  1  one-cycle strobe, coincident with each sector change.
- rev_count  output  REV_BITS  signed electrical revolution count.

## Operation
- Code map, sector -> {hall_3, hall_2, hall_1}:
  - 0 -> 001
  - 1 -> 101
  - 2 -> 100
  - 3 -> 110
  - 4 -> 010
  - 5 -> 011
- Adjacent codes differ in exactly one bit. Hall outputs must never show a multi-bit transition, except when entering or leaving a forced fault code.
- State: dwell counter cnt, latched period period_q, sector, rev_count.
- Period latch: period_q <= sector_period when en=0, or when period_q=0, or on a step edge. A change to sector_period mid-sector takes effect from the next sector.
- Step rule, evaluated each edge with en=1, period_q!=0 and fault_mode!=11:
  - If cnt == period_q-1: cnt <= 0, step.
  - Otherwise: cnt <= cnt+1.
- Step, forward (dir=0): sector <= sector==5 ? 0 : sector+1. On the 5->0 wrap, rev_count += 1.
- Step, reverse (dir=1): sector <= sector==0 ? 5 : sector-1. On the 0->5 wrap, rev_count -= 1.
- dir is sampled only at step edges. A direction change never skips or repeats a sector.
- rev_count wraps modulo 2^REV_BITS (two's complement).
- en=0: cnt <= 0; sector, Halls and rev_count hold.
- period_q=0 (stall): cnt held at 0, no steps.
- fault_mode=11: cnt and sector hold.
- Hall outputs:
  - Registered as code(sector_next) under normal operation.
  - fault_mode 01 or 10 overrides the output register with 000 or 111 from the next edge. Internal stepping continues underneath.
  - On fault release, the Halls show code(current sector) on the next edge.
- step_pulse: registered, high for the single cycle in which the new Hall code first appears. It is suppressed while fault_mode is 01 or 10, even though the sector advances.

## Timing
- Reset values:
  - sector=0, Halls={0,0,1} (hall_1=1)
  - cnt=0, period_q=0, rev_count=0, step_pulse=0
- All outputs are registered. There is no combinational path from inputs to outputs.
- With constant period P>=1 and en=1, each sector lasts exactly P cycles. P=1 steps on every edge.
- After en rises with period_q already latched at P, the first Hall change occurs on the P-th edge at which en=1.
- Startup when reset releases with en=1 (period_q=0): the first enabled edge latches P, then P further edges elapse before the first step.
- fault_mode changes reach the Hall outputs 1 cycle later.
- Reset asserted mid-sector returns all state to the reset values on that edge, regardless of en or fault_mode.

## Test plan
- Reset, en=0 for 10 cycles -> Halls 001, sector 0, rev_count 0, step_pulse never high.
- en=1, dir=0, P=4 latched -> Hall sequence 001,101,100,110,010,011,001 with exactly 4 cycles per code. step_pulse every 4th cycle. rev_count=1 after 24 enabled cycles.
- dir=1, P=3 from reset state -> sequence 001,011,010,110,100,101,001. rev_count=0xFFFF (-1) after 18 enabled cycles. Flip dir mid-sector -> next step reverses, no sector skipped.
- P=4, change sector_period to 8 at cycle 2 of a sector -> current sector still 4 cycles, next sector 8 cycles.
- fault_mode=01 for 6 cycles at P=4 -> Halls 000 one cycle after assertion, no step_pulse. Sector index advances internally. On release, Halls show code(sector) next cycle. fault_mode=11 -> Halls and sector frozen.
- Boundary cases:
  - P=0 with en=1 -> no steps.
  - Drop en mid-sector -> Halls hold. Re-enable -> full P-cycle dwell.
  - Assert rst_ctrl mid-run -> reset values on the same edge.
